// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: two-state IDLE/EXEC sequencer around a DATA_W-bit ALU
// and a 2^ADDR_W-word register file, with a valid/ready instruction port.
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] operand,
  input  logic [ADDR_W-1:0] addr,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, EXEC} state_e;

  state_e              state_q;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   opnd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, c_q, c_d, err_q, err_d, rv_q;
  logic                wr_z, mem_we;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_rd;

  assign mem_rd       = mem_q[addr_q];
  assign instr_ready  = (state_q == IDLE);
  assign result_valid = rv_q;
  // Accumulator is only written at retirement, so it doubles as the held result.
  assign result       = acc_q;
  assign flag_z       = z_q;
  assign flag_c       = c_q;
  assign err          = err_q;

  always_comb begin
    acc_d  = acc_q;
    c_d    = c_q;
    wr_z   = 1'b1;
    err_d  = 1'b0;
    mem_we = 1'b0;
    sum_w  = '0;
    case (op_q)
      4'h0: begin
        sum_w = {1'b0, acc_q} + {1'b0, opnd_q};
        acc_d = sum_w[DATA_W-1:0];
        c_d   = sum_w[DATA_W];
      end
      4'h1: begin
        // Top bit of the widened difference is the borrow.
        sum_w = {1'b0, acc_q} - {1'b0, opnd_q};
        acc_d = sum_w[DATA_W-1:0];
        c_d   = sum_w[DATA_W];
      end
      4'h2: begin
        mem_we = 1'b1;
        wr_z   = 1'b0;
      end
      4'h3: acc_d = mem_rd;
      4'h4: acc_d = opnd_q;
      4'h5: acc_d = acc_q & opnd_q;
      4'h6: acc_d = acc_q | opnd_q;
      4'h7: acc_d = acc_q ^ opnd_q;
      4'h8: acc_d = ~acc_q;
      4'h9: begin
        acc_d = {acc_q[DATA_W-2:0], 1'b0};
        c_d   = acc_q[DATA_W-1];
      end
      4'hA: begin
        acc_d = {1'b0, acc_q[DATA_W-1:1]};
        c_d   = acc_q[0];
      end
      4'hB: begin
        sum_w = {1'b0, acc_q} + {1'b0, mem_rd};
        acc_d = sum_w[DATA_W-1:0];
        c_d   = sum_w[DATA_W];
      end
      4'hC: wr_z = 1'b0;
      default: begin
        wr_z  = 1'b0;
        err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          op_q    <= opcode;
          opnd_q  <= operand;
          addr_q  <= addr;
          state_q <= EXEC;
        end
        EXEC: begin
          acc_q <= acc_d;
          c_q   <= c_d;
          if (wr_z) z_q <= (acc_d == '0);
          err_q <= err_d;
          if (mem_we) mem_q[addr_q] <= acc_q;
          rv_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: integer-arithmetic reference model checked every
// cycle, plus literal expectations for the directed instruction sequences.
module tb_acc_cpu_core;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int MASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    opcode;
  logic [DW-1:0] operand;
  logic [AW-1:0] addr;
  logic          result_valid;
  logic [DW-1:0] result;
  logic          flag_z, flag_c, err;

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .operand(operand), .addr(addr),
    .result_valid(result_valid), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, rv_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: reset values, then each accepted instruction is retired
  // one edge after acceptance using plain integer arithmetic.
  int m_acc = 0, m_z = 0, m_c = 0, m_err = 0, m_rv = 0, m_ready = 1;
  int m_mem [1 << AW];
  int p_op, p_opnd, p_addr;
  bit m_pend = 0;

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_acc = 0; m_z = 0; m_c = 0; m_err = 0; m_rv = 0; m_ready = 1; m_pend = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
      end else begin
        m_rv = 0;
        if (m_pend) begin
          int a, n, mv;
          bit wz;
          a = m_acc; n = a; mv = m_mem[p_addr]; wz = 1; m_err = 0;
          case (p_op)
            0:  begin n = a + p_opnd; m_c = (n > MASK); end
            1:  begin m_c = (p_opnd > a); n = a - p_opnd; end
            2:  begin m_mem[p_addr] = a; wz = 0; end
            3:  n = mv;
            4:  n = p_opnd;
            5:  n = a & p_opnd;
            6:  n = a | p_opnd;
            7:  n = a ^ p_opnd;
            8:  n = MASK - a;
            9:  begin m_c = (a >> (DW - 1)) & 1; n = a * 2; end
            10: begin m_c = a & 1; n = a / 2; end
            11: begin n = a + mv; m_c = (n > MASK); end
            12: wz = 0;
            default: begin wz = 0; m_err = 1; end
          endcase
          m_acc = n & MASK;
          if (wz) m_z = (m_acc == 0);
          m_pend = 0; m_rv = 1; m_ready = 1;
        end else if (instr_valid) begin
          p_op = opcode; p_opnd = operand; p_addr = addr;
          m_pend = 1; m_ready = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("ready", instr_ready, m_ready);
      chk("rvalid", result_valid, m_rv);
      chk("result", result, m_acc);
      chk("flag_z", flag_z, m_z);
      chk("flag_c", flag_c, m_c);
      chk("err", err, m_err);
      if (result_valid === 1'b1) rv_cnt++;
    end
  end

  // Called at a negedge with the core idle; returns at the negedge where the
  // retirement strobe is visible.
  task automatic send(input int op, input int opnd, input int ad);
    int n;
    opcode = op[3:0]; operand = opnd[DW-1:0]; addr = ad[AW-1:0]; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (result_valid !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (result_valid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL timeout op %0h: no result_valid", op);
    end
  endtask

  int bop   [6] = '{4, 0, 7, 0, 7, 0};
  int bopnd [6] = '{'h10, 1, 'hFF, 2, 'h0F, 1};
  int base;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; operand = '0; addr = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_result", result, 0);
    rst = 1'b0;

    send(4, 'h7F, 0); chk("ldi_7f", result, 'h7F);
    send(0, 'h01, 0); chk("add_80", result, 'h80); chk("add_80_z", flag_z, 0); chk("add_80_c", flag_c, 0);
    send(0, 'h80, 0); chk("add_00", result, 'h00); chk("add_00_z", flag_z, 1); chk("add_00_c", flag_c, 1);

    send(4, 'h05, 0);
    send(1, 'h06, 0); chk("sub_ff", result, 'hFF); chk("sub_c", flag_c, 1);
    send(10, 0, 0);   chk("shr_7f", result, 'h7F); chk("shr_c", flag_c, 1);
    send(9, 0, 0);    chk("shl_fe", result, 'hFE); chk("shl_c", flag_c, 0);
    send(8, 0, 0);    chk("not_01", result, 'h01); chk("not_z", flag_z, 0);

    send(4, 'hA5, 0);
    send(2, 0, 3);    chk("store_res", result, 'hA5);
    send(4, 0, 0);
    send(3, 0, 3);    chk("load_a5", result, 'hA5);
    send(11, 0, 3);   chk("addm_4a", result, 'h4A); chk("addm_c", flag_c, 1);
    send(4, 'h3C, 0);
    send(2, 0, 15);
    send(3, 0, 3);    chk("load3_indep", result, 'hA5);
    send(3, 0, 15);   chk("load15", result, 'h3C);

    // Back-to-back: valid held high, each instruction presented for two edges.
    @(negedge clk);
    base = rv_cnt;
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      opcode = bop[i][3:0]; operand = bopnd[i][DW-1:0]; addr = '0;
      @(negedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    chk("burst_retires", rv_cnt - base, 6);
    chk("burst_result", result, 'h00);
    chk("burst_c", flag_c, 1);

    send(4, 'h33, 0);
    send('hE, 0, 0);  chk("ill_err", err, 1); chk("ill_res", result, 'h33);
    chk("ill_z", flag_z, 0); chk("ill_c", flag_c, 1);
    send(12, 0, 0);   chk("nop_err", err, 0); chk("nop_res", result, 'h33);

    // Reset during the EXEC cycle of a STORE.
    send(4, 'h5A, 0);
    opcode = 4'h2; addr = 2; instr_valid = 1'b1;
    @(posedge clk);
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rstx_ready", instr_ready, 1);
    chk("rstx_rv", result_valid, 0);
    chk("rstx_res", result, 0);
    @(negedge clk);
    rst = 1'b0;
    send(3, 0, 2);    chk("abort_mem2", result, 0);
    send(3, 0, 3);    chk("rst_mem3", result, 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
